// File: rtl/road_packet_assembler.sv
// road_packet_assembler: SVT cable words -> FIFO -> road/end-of-event packets.
// Ports: clk, reset_pulsar (async, active-low); data_in/ds strobe in, hold out;
//   out_valid/out_ready handshake with out_road, out_mask, out_hits, out_ee,
//   out_tag, out_err; overflow is sticky until reset.
module road_packet_assembler #(
   parameter int FIFO_DEPTH = 16,
   parameter int HOLD_THR   = 12
) (
   input  logic          clk,
   input  logic          reset_pulsar,
   input  logic [22:0]   data_in,
   input  logic          ds,
   output logic          hold,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [20:0]   out_road,
   output logic [5:0]    out_mask,
   output logic [107:0]  out_hits,
   output logic          out_ee,
   output logic [20:0]   out_tag,
   output logic          out_err,
   output logic          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] HOLD_CNT = (AW+1)'(HOLD_THR);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      EMIT
   } state_t;

   logic          ds_q;
   logic          armed;
   logic          strobe;
   logic          wr_pend;
   logic [22:0]   wr_data;

   logic [22:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          ovf;
   logic          full;
   logic          pop;
   logic          do_wr;
   logic [22:0]   rd_word;

   state_t        state, state_n;
   logic [5:0]    mask, mask_n;
   logic [107:0]  hits, hits_n;
   logic          err, err_n;
   logic [20:0]   id, id_n;
   logic          ee, ee_n;

   logic          is_hit;
   logic          is_road;
   logic          is_eoe;
   logic          is_bad;
   logic          emit;

   // armed blocks a strobe until ds has really been seen high after reset
   assign strobe = armed & ds_q & ~ds;

   always_ff @(posedge clk or negedge reset_pulsar) begin
      if (!reset_pulsar) begin
         ds_q    <= 1'b1;
         armed   <= 1'b0;
         wr_pend <= 1'b0;
         wr_data <= '0;
      end else begin
         ds_q    <= ds;
         wr_pend <= strobe;
         wr_data <= data_in;
         if (ds)
            armed <= 1'b1;
      end
   end

   assign full    = (count == FULL_CNT);
   assign pop     = (state != EMIT) && (count != '0);
   assign do_wr   = wr_pend && (!full || pop);
   assign rd_word = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset_pulsar) begin
      if (!reset_pulsar) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (wr_pend && full && !pop)
            ovf <= 1'b1;
      end
   end

   // layers 6/7 fold into the illegal class so the decode stays one-hot
   assign is_bad  = (rd_word[22:21] == 2'b10) ||
                    ((rd_word[22:21] == 2'b00) && (rd_word[20:19] == 2'b11));
   assign is_hit  = (rd_word[22:21] == 2'b00) && (rd_word[20:19] != 2'b11);
   assign is_road = (rd_word[22:21] == 2'b01);
   assign is_eoe  = (rd_word[22:21] == 2'b11);

   always_ff @(posedge clk or negedge reset_pulsar) begin
      if (!reset_pulsar) begin
         state <= IDLE;
         mask  <= '0;
         hits  <= '0;
         err   <= 1'b0;
         id    <= '0;
         ee    <= 1'b0;
      end else begin
         state <= state_n;
         mask  <= mask_n;
         hits  <= hits_n;
         err   <= err_n;
         id    <= id_n;
         ee    <= ee_n;
      end
   end

   always_comb begin
      state_n = state;
      mask_n  = mask;
      hits_n  = hits;
      err_n   = err;
      id_n    = id;
      ee_n    = ee;
      case (state)
         EMIT: begin
            if (out_ready) begin
               state_n = IDLE;
               mask_n  = '0;
               hits_n  = '0;
               err_n   = 1'b0;
            end
         end
         IDLE, COLLECT: begin
            if (pop) begin
               unique case (1'b1)
                  is_hit: begin
                     for (int i = 0; i < 6; i++) begin
                        if (rd_word[20:18] == 3'(i)) begin
                           if (mask[i]) begin
                              err_n = 1'b1;
                           end else begin
                              mask_n[i]          = 1'b1;
                              hits_n[18*i +: 18] = rd_word[17:0];
                           end
                        end
                     end
                     state_n = COLLECT;
                  end
                  is_road: begin
                     id_n    = rd_word[20:0];
                     ee_n    = 1'b0;
                     state_n = EMIT;
                  end
                  is_eoe: begin
                     // hits without a road are orphans
                     if (state == COLLECT)
                        err_n = 1'b1;
                     mask_n  = '0;
                     hits_n  = '0;
                     id_n    = rd_word[20:0];
                     ee_n    = 1'b1;
                     state_n = EMIT;
                  end
                  is_bad: begin
                     err_n = 1'b1;
                  end
               endcase
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign emit      = (state == EMIT);
   assign out_valid = emit;
   assign out_road  = (emit && !ee) ? id : '0;
   assign out_tag   = (emit && ee) ? id : '0;
   assign out_ee    = emit && ee;
   assign out_mask  = emit ? mask : '0;
   assign out_hits  = emit ? hits : '0;
   assign out_err   = emit && err;
   assign hold      = (count >= HOLD_CNT);
   assign overflow  = ovf;

endmodule

// File: tb/tb_road_packet_assembler.sv
// tb_road_packet_assembler: scoreboard bench for road_packet_assembler.
// Expected packets are queued as words are driven and matched on handshake.
module tb_road_packet_assembler;

   logic          clk = 1'b0;
   logic          reset_pulsar;
   logic [22:0]   data_in;
   logic          ds;
   logic          hold;
   logic          out_valid;
   logic          out_ready;
   logic [20:0]   out_road;
   logic [5:0]    out_mask;
   logic [107:0]  out_hits;
   logic          out_ee;
   logic [20:0]   out_tag;
   logic          out_err;
   logic          overflow;

   always #5 clk = ~clk;

   road_packet_assembler #(
      .FIFO_DEPTH(16),
      .HOLD_THR(12)
   ) dut (
      .clk(clk),
      .reset_pulsar(reset_pulsar),
      .data_in(data_in),
      .ds(ds),
      .hold(hold),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_road(out_road),
      .out_mask(out_mask),
      .out_hits(out_hits),
      .out_ee(out_ee),
      .out_tag(out_tag),
      .out_err(out_err),
      .overflow(overflow)
   );

   typedef struct {
      logic [20:0]  road;
      logic [5:0]   mask;
      logic [107:0] hits;
      logic         ee;
      logic [20:0]  tag;
      logic         err;
   } pkt_t;

   pkt_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic pkt_t mk(input logic [20:0] road, input logic [5:0] mask,
                               input logic [107:0] hits, input logic ee,
                               input logic [20:0] tag, input logic err);
      pkt_t p;
      p.road = road;
      p.mask = mask;
      p.hits = hits;
      p.ee   = ee;
      p.tag  = tag;
      p.err  = err;
      return p;
   endfunction

   function automatic logic [107:0] h6(input logic [17:0] l0, l1, l2,
                                       l3, l4, l5);
      return {l5, l4, l3, l2, l1, l0};
   endfunction

   always @(negedge clk) begin
      pkt_t e;
      if (reset_pulsar && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("extra_pkt", 128'(out_valid), 128'(1'b0));
         end else begin
            e = sb.pop_front();
            chk("pkt_ee", 128'(out_ee), 128'(e.ee));
            if (e.ee)
               chk("pkt_tag", 128'(out_tag), 128'(e.tag));
            else
               chk("pkt_road", 128'(out_road), 128'(e.road));
            chk("pkt_mask", 128'(out_mask), 128'(e.mask));
            chk("pkt_hits", 128'(out_hits), 128'(e.hits));
            chk("pkt_err", 128'(out_err), 128'(e.err));
         end
      end
   end

   task automatic send(input logic [22:0] w);
      @(negedge clk);
      data_in = w;
      ds      = 1'b0;
      @(negedge clk);
      ds      = 1'b1;
   endtask

   task automatic drain();
      int k = 0;
      while ((sb.size() != 0 || out_valid) && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("drain", 128'(sb.size()), 128'(0));
      repeat (6) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset_pulsar = 1'b0;
      ds           = 1'b1;
      data_in      = '0;
      out_ready    = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_hold", 128'(hold), 128'(0));
      chk("rst_ovf", 128'(overflow), 128'(0));
      chk("rst_road", 128'(out_road), 128'(0));
      chk("rst_hits", 128'(out_hits), 128'(0));
      reset_pulsar = 1'b1;
      repeat (2) @(negedge clk);

      // minimum latency, ds held low for many cycles yields one word
      sb.push_back(mk(21'h000001, 6'h00, '0, 1'b0, '0, 1'b0));
      @(negedge clk);
      data_in = 23'h200001;
      ds      = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid && k < 10);
      chk("latency", 128'(k), 128'(3));
      repeat (4) @(negedge clk);
      ds = 1'b1;
      drain();

      // full six-layer road
      sb.push_back(mk(21'h087e23, 6'h3f,
                      h6(18'h0cc0c, 18'h139da, 18'h01a25,
                         18'h0c6c6, 18'h132d6, 18'h1feed),
                      1'b0, '0, 1'b0));
      send(23'h00cc0c); send(23'h0539da); send(23'h081a25);
      send(23'h0cc6c6); send(23'h1132d6); send(23'h15feed);
      send(23'h287e23);

      // duplicates keep the first hit and flag err
      sb.push_back(mk(21'h087e23, 6'h03,
                      h6(18'h0cc0c, 18'h139da, '0, '0, '0, '0),
                      1'b0, '0, 1'b1));
      send(23'h00cc0c); send(23'h00cc0c); send(23'h0539da);
      send(23'h04b68c); send(23'h287e23);

      // two bare end-of-event packets
      sb.push_back(mk('0, 6'h00, '0, 1'b1, 21'h000001, 1'b0));
      sb.push_back(mk('0, 6'h00, '0, 1'b1, 21'h000002, 1'b0));
      send(23'h600001); send(23'h600002);

      // layer-7 hit, illegal word, orphan hits, then clean partial road
      sb.push_back(mk(21'h090f34, 6'h00, '0, 1'b0, '0, 1'b1));
      send(23'h1c0001); send(23'h290f34);
      sb.push_back(mk(21'h000005, 6'h00, '0, 1'b0, '0, 1'b1));
      send(23'h4abcde); send(23'h200005);
      sb.push_back(mk('0, 6'h00, '0, 1'b1, 21'h000003, 1'b1));
      send(23'h00cc0c); send(23'h600003);
      sb.push_back(mk(21'h0000f0, 6'h24,
                      h6('0, '0, 18'h01a25, '0, '0, 18'h1feed),
                      1'b0, '0, 1'b0));
      send(23'h081a25); send(23'h15feed); send(23'h2000f0);
      drain();

      // back-pressure: stall one packet while 20 words arrive
      @(posedge clk); #1 out_ready = 1'b0;
      sb.push_back(mk(21'h0000aa, 6'h00, '0, 1'b0, '0, 1'b0));
      send(23'h2000aa);
      for (int i = 0; i < 20; i++) begin
         if (i < 16)
            sb.push_back(mk(21'h000100 + 21'(i), 6'h00, '0, 1'b0, '0, 1'b0));
         send(23'h200100 + 23'(i));
         @(posedge clk); #1;
         if (i == 10) chk("hold_11", 128'(hold), 128'(0));
         if (i == 11) chk("hold_12", 128'(hold), 128'(1));
         if (i == 15) chk("ovf_16", 128'(overflow), 128'(0));
         if (i == 16) chk("ovf_17", 128'(overflow), 128'(1));
         if (i == 5 || i == 19) begin
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_road", 128'(out_road), 128'(21'h0000aa));
         end
      end
      @(posedge clk); #1 out_ready = 1'b1;
      drain();
      chk("ovf_sticky", 128'(overflow), 128'(1));
      chk("hold_low", 128'(hold), 128'(0));

      // reset mid-collect, ds low across release must not strobe
      send(23'h00cc0c);
      repeat (2) @(negedge clk);
      #2 reset_pulsar = 1'b0;
      data_in = 23'h200055;
      ds      = 1'b0;
      #1;
      chk("arst_valid", 128'(out_valid), 128'(0));
      chk("arst_hold", 128'(hold), 128'(0));
      chk("arst_ovf", 128'(overflow), 128'(0));
      @(negedge clk);
      reset_pulsar = 1'b1;
      repeat (5) @(negedge clk);
      chk("no_rel_strobe", 128'(out_valid), 128'(0));
      ds = 1'b1;
      @(negedge clk);
      sb.push_back(mk(21'h000077, 6'h00, '0, 1'b0, '0, 1'b0));
      send(23'h200077);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
